// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : 640x480@60 VGA raster timing generator. Divides mainClk down to
//            the pixel rate, runs the horizontal/vertical counters, issues
//            frame-buffer read addresses for a 2**SCALE_SHIFT upscaled image
//            and drives sync/blank through a pixel-rate delay line so they
//            line up with the SPRAM read data at the DAC.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV     = 2,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int PIPE_DLY    = 1
) (
    input  logic              mainClk,
    input  logic              nreset,
    output logic              pixEn,
    output logic [9:0]        hCount,
    output logic [9:0]        vCount,
    output logic [ADDR_W-1:0] readAddr,
    output logic              frameStart,
    output logic              hSync,
    output logic              vSync,
    output logic              syncB,
    output logic              blankB
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int IMG_W    = H_ACTIVE >> SCALE_SHIFT;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Inactive delay-line value: {hs_n, vs_n, active} = sync high, blanked
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    logic [DIV_W-1:0]  divCnt_q, divCnt_d;
    logic              pixEn_q, pixEn_d;
    logic [9:0]        hCount_q, hCount_d;
    logic [9:0]        vCount_q, vCount_d;
    logic [ADDR_W-1:0] readAddr_q, readAddr_d;
    logic              frameStart_q, frameStart_d;

    logic              w_active;
    logic              w_hs_n;
    logic              w_vs_n;
    logic              w_h_last;
    logic              w_v_last;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_raw;
    logic [2:0]        w_sync_out;

    // Raw raster decode on the current counters
    assign w_h_last = (hCount_q == 10'(H_TOTAL - 1));
    assign w_v_last = (vCount_q == 10'(V_TOTAL - 1));
    assign w_active = (hCount_q < 10'(H_ACTIVE)) && (vCount_q < 10'(V_ACTIVE));
    assign w_hs_n   = !((hCount_q >= 10'(HS_START)) && (hCount_q < 10'(HS_END)));
    assign w_vs_n   = !((vCount_q >= 10'(VS_START)) && (vCount_q < 10'(VS_END)));
    assign w_raw    = {w_hs_n, w_vs_n, w_active};

    // Scaled image address; arithmetic kept at ADDR_W so the result wraps
    // exactly like a truncated full-width product
    assign w_addr = ADDR_W'(vCount_q >> SCALE_SHIFT) * ADDR_W'(IMG_W)
                  + ADDR_W'(hCount_q >> SCALE_SHIFT);

    // Next-state: pixel divider, raster counters, address and frame pulse
    always_comb begin
        divCnt_d     = divCnt_q;
        pixEn_d      = (divCnt_q == DIV_W'(CLK_DIV - 1));
        hCount_d     = hCount_q;
        vCount_d     = vCount_q;
        readAddr_d   = w_active ? w_addr : '0;
        frameStart_d = pixEn_q && w_h_last && w_v_last;

        if (divCnt_q == DIV_W'(CLK_DIV - 1)) begin
            divCnt_d = '0;
        end else begin
            divCnt_d = divCnt_q + 1'b1;
        end

        if (pixEn_q) begin
            if (w_h_last) begin
                hCount_d = '0;
                vCount_d = w_v_last ? 10'd0 : vCount_q + 10'd1;
            end else begin
                hCount_d = hCount_q + 10'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            divCnt_q     <= '0;
            pixEn_q      <= 1'b0;
            hCount_q     <= '0;
            vCount_q     <= '0;
            readAddr_q   <= '0;
            frameStart_q <= 1'b0;
        end else begin
            divCnt_q     <= divCnt_d;
            pixEn_q      <= pixEn_d;
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            readAddr_q   <= readAddr_d;
            frameStart_q <= frameStart_d;
        end
    end

    if (PIPE_DLY == 0) begin : g_nodly
        logic [2:0] out_q;

        // No alignment delay: register the raw decode every clock
        always_ff @(posedge mainClk or negedge nreset) begin
            if (!nreset) begin
                out_q <= SYNC_IDLE;
            end else begin
                out_q <= w_raw;
            end
        end

        assign w_sync_out = out_q;
    end else begin : g_dly
        logic [2:0] stage_q [PIPE_DLY];

        // Pixel-rate shift register aligning sync/blank with SPRAM data
        always_ff @(posedge mainClk or negedge nreset) begin
            if (!nreset) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    stage_q[i] <= SYNC_IDLE;
                end
            end else if (pixEn_q) begin
                stage_q[0] <= w_raw;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign w_sync_out = stage_q[PIPE_DLY-1];
    end

    assign pixEn      = pixEn_q;
    assign hCount     = hCount_q;
    assign vCount     = vCount_q;
    assign readAddr   = readAddr_q;
    assign frameStart = frameStart_q;
    assign hSync      = w_sync_out[2];
    assign vSync      = w_sync_out[1];
    assign blankB     = w_sync_out[0];
    assign syncB      = 1'b0;

endmodule
`default_nettype wire
